// File: rtl/io_controller_if.sv
// CPU-side I/O transaction bus for io_controller.
// The master drives the request; the slave (io_controller) answers with
// stall/done and the captured input value.
interface io_controller_if;
  logic        req;
  logic        io;
  logic [31:0] data_out;
  logic        stall;
  logic        done;
  logic [31:0] data_in;

  modport master (
    output req, io, data_out,
    input  stall, done, data_in
  );

  modport slave (
    input  req, io, data_out,
    output stall, done, data_in
  );
endinterface

// File: rtl/io_controller.sv
// io_controller: sequences CPU IN/OUT instructions against board I/O.
// IN stalls the CPU until the operator presses and releases Confirm, then
// returns the zero-extended switch value. OUT latches a value into the
// display holding register. Each completed transaction gives one Done pulse.
// Optional feature: define IO_CONFIRM_DEBOUNCE_EN to debounce Confirm for
// DEBOUNCE_CYCLES stable samples; otherwise the synchronized level is used
// directly and DEBOUNCE_CYCLES has no effect.
module io_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SWITCH_WIDTH    = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  io_controller_if.slave          cpu,
  input  logic [SWITCH_WIDTH-1:0] raw_input,
  input  logic                    confirm,
  output logic [31:0]             display_data,
  output logic                    display_valid,
  output logic                    waiting
);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_PRESS   = 3'd1,
    ST_WAIT_RELEASE = 3'd2,
    ST_OUT_WRITE    = 3'd3,
    ST_DONE         = 3'd4
  } state_t;

  state_t                  state;
  logic                    sync1;
  logic                    sync2;
  logic                    conf_db;
  logic                    conf_prev;
  logic [SWITCH_WIDTH-1:0] hold;
  logic [SWITCH_WIDTH-1:0] data_in_r;

  // Two-flop synchronizer for the asynchronous pushbutton.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= confirm;
      sync2 <= sync1;
    end
  end

`ifdef IO_CONFIRM_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CNT_W-1:0] db_cnt;

  // Accept a new Confirm level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt  <= '0;
      conf_db <= 1'b0;
    end else if (sync2 != conf_db) begin
      if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        conf_db <= ~conf_db;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end
`else
  assign conf_db = sync2;
`endif

  // Previous debounced level, for press (rising edge) detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conf_prev <= 1'b0;
    end else begin
      conf_prev <= conf_db;
    end
  end

  // Transaction FSM with registered capture, display and data-in registers.
  // A dropped request in any waiting/working state aborts without Done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      hold          <= '0;
      data_in_r     <= '0;
      display_data  <= 32'h0000_0000;
      display_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu.req) begin
            state <= cpu.io ? ST_OUT_WRITE : ST_WAIT_PRESS;
          end
        end
        ST_WAIT_PRESS: begin
          if (!cpu.req) begin
            state <= ST_IDLE;
          end else if (conf_db && !conf_prev) begin
            hold  <= raw_input;
            state <= ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (!cpu.req) begin
            state <= ST_IDLE;
          end else if (!conf_db) begin
            data_in_r <= hold;
            state     <= ST_DONE;
          end
        end
        ST_OUT_WRITE: begin
          if (!cpu.req) begin
            state <= ST_IDLE;
          end else begin
            display_data  <= cpu.data_out;
            display_valid <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the registered state; stall must follow req in the
  // same cycle so the CPU freezes on the instruction that raised it.
  assign cpu.stall   = cpu.req && (state != ST_DONE);
  assign cpu.done    = (state == ST_DONE);
  assign waiting     = (state == ST_WAIT_PRESS) || (state == ST_WAIT_RELEASE);
  assign cpu.data_in = {{(32-SWITCH_WIDTH){1'b0}}, data_in_r};

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller (DEBOUNCE_CYCLES = 4).
// A behavioural model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations.
module tb_io_controller;
  localparam int D  = 4;
  localparam int SW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [SW-1:0] raw_input = '0;
  logic          confirm = 1'b0;
  logic [31:0]   display_data;
  logic          display_valid;
  logic          waiting;

  int n_total = 0;
  int n_pass  = 0;

  io_controller_if bus();

  io_controller #(.DEBOUNCE_CYCLES(D), .SWITCH_WIDTH(SW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu          (bus.slave),
    .raw_input    (raw_input),
    .confirm      (confirm),
    .display_data (display_data),
    .display_valid(display_valid),
    .waiting      (waiting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 awaiting press, 2 awaiting release, 3 writing display, 4 done
  int          m_phase;
  logic        m_c1, m_y;
  logic [D-1:0] m_win;
  logic        m_db_r, m_prev;
  logic [SW-1:0] m_hold;
  logic [31:0] m_din, m_disp;
  logic        m_valid;
  logic        m_db;
  logic [D-1:0] win_next;

`ifdef IO_CONFIRM_DEBOUNCE_EN
  assign m_db = m_db_r;
`else
  assign m_db = m_y;
`endif
  assign win_next = {m_win[D-2:0], m_y};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_c1 <= 1'b0; m_y <= 1'b0; m_win <= '0;
      m_db_r <= 1'b0; m_prev <= 1'b0; m_hold <= '0;
      m_din <= 32'h0; m_disp <= 32'h0; m_valid <= 1'b0;
    end else begin
      m_c1 <= confirm;
      m_y  <= m_c1;
      m_win <= win_next;
      // level flips once the last D synchronized samples all disagree with it
      if (m_db_r ? (win_next == '0) : (&win_next)) m_db_r <= ~m_db_r;
      m_prev <= m_db;
      case (m_phase)
        0: if (bus.req) m_phase <= bus.io ? 3 : 1;
        1: if (!bus.req) m_phase <= 0;
           else if (m_db && !m_prev) begin m_hold <= raw_input; m_phase <= 2; end
        2: if (!bus.req) m_phase <= 0;
           else if (!m_db) begin m_din <= {14'd0, m_hold}; m_phase <= 4; end
        3: if (!bus.req) m_phase <= 0;
           else begin m_disp <= bus.data_out; m_valid <= 1'b1; m_phase <= 4; end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("stall",         {31'd0, bus.stall},     {31'd0, bus.req && (m_phase != 4)});
      chk("done",          {31'd0, bus.done},      {31'd0, m_phase == 4});
      chk("waiting",       {31'd0, waiting},       {31'd0, (m_phase == 1) || (m_phase == 2)});
      chk("data_in",       bus.data_in,            m_din);
      chk("display_data",  display_data,           m_disp);
      chk("display_valid", {31'd0, display_valid}, {31'd0, m_valid});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic drop_req();
    cyc(1);
    bus.req = 1'b0;
  endtask

  int dcount;

  initial begin
    bus.req = 1'b0; bus.io = 1'b0; bus.data_out = 32'h0;
    #1 rst = 1'b1;
    cyc(3);
    rst = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_data_in", bus.data_in, 32'h0);
    chk("rst_disp", display_data, 32'h0);
    chk("rst_valid", {31'd0, display_valid}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);

    // OUT: three-cycle transaction
    cyc(1);
    bus.req = 1'b1; bus.io = 1'b1; bus.data_out = 32'h1234ABCD;
    @(negedge clk);
    chk("out_c0_stall", {31'd0, bus.stall}, 32'd1);
    chk("out_c0_disp", display_data, 32'h0);
    @(negedge clk);
    chk("out_c1_stall", {31'd0, bus.stall}, 32'd1);
    chk("out_c1_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    chk("out_c2_done", {31'd0, bus.done}, 32'd1);
    chk("out_c2_stall", {31'd0, bus.stall}, 32'd0);
    chk("out_c2_disp", display_data, 32'h1234ABCD);
    chk("out_c2_valid", {31'd0, display_valid}, 32'd1);
    drop_req();
    @(negedge clk);
    chk("out_single_done", {31'd0, bus.done}, 32'd0);

    // IN with a clean press and release
    cyc(2);
    raw_input = 18'h2A5F3; bus.req = 1'b1; bus.io = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("in_waiting", {31'd0, waiting}, 32'd1);
    cyc(1);
    confirm = 1'b1;
    cyc(10);
    confirm = 1'b0;
    wait_done("in_done_timeout", 30);
    chk("in_data", bus.data_in, 32'h0002A5F3);
    chk("in_stall_in_done", {31'd0, bus.stall}, 32'd0);
    drop_req();
    @(negedge clk);
    chk("in_single_done", {31'd0, bus.done}, 32'd0);

    // bounce: short pulses must not count as a press when debounced
    cyc(2);
    raw_input = 18'h11111; bus.req = 1'b1; bus.io = 1'b0;
    cyc(3);
    for (int w = 1; w <= 3; w++) begin
      confirm = 1'b1;
      cyc(w);
      confirm = 1'b0;
      cyc(6);
    end
`ifdef IO_CONFIRM_DEBOUNCE_EN
    @(negedge clk);
    chk("bounce_waiting", {31'd0, waiting}, 32'd1);
    chk("bounce_data", bus.data_in, 32'h0002A5F3);
`endif
    drop_req();
    cyc(4);

    // held button: must release and press again before capture
    confirm = 1'b1;
    cyc(10);
    raw_input = 18'h3C3C3; bus.req = 1'b1; bus.io = 1'b0;
    cyc(8);
    @(negedge clk);
    chk("held_waiting", {31'd0, waiting}, 32'd1);
    chk("held_no_done", {31'd0, bus.done}, 32'd0);
    cyc(1);
    confirm = 1'b0;
    cyc(8);
    raw_input = 18'h0ABCD; confirm = 1'b1;
    cyc(8);
    raw_input = 18'h3FFFF; confirm = 1'b0;
    wait_done("held_done_timeout", 30);
    chk("held_data", bus.data_in, 32'h0000ABCD);
    drop_req();
    cyc(3);

    // abort in WAIT_RELEASE: no Done, data_in unchanged
    raw_input = 18'h12345; bus.req = 1'b1; bus.io = 1'b0;
    cyc(3);
    confirm = 1'b1;
    cyc(10);
    @(negedge clk);
    chk("abort_waiting", {31'd0, waiting}, 32'd1);
    cyc(1);
    bus.req = 1'b0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    chk("abort_no_done", dcount, 32'd0);
    chk("abort_data", bus.data_in, 32'h0000ABCD);
    chk("abort_idle", {31'd0, waiting}, 32'd0);
    confirm = 1'b0;
    cyc(10);

    // asynchronous reset in WAIT_PRESS takes effect before the next edge
    bus.req = 1'b1; bus.io = 1'b0;
    cyc(3);
    #1;
    bus.req = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_data_in", bus.data_in, 32'h0);
    chk("arst_disp", display_data, 32'h0);
    chk("arst_valid", {31'd0, display_valid}, 32'd0);
    chk("arst_waiting", {31'd0, waiting}, 32'd0);
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_stall", {31'd0, bus.stall}, 32'd0);
    cyc(1);
    rst = 1'b0;

    // OUT after reset with all-ones data
    cyc(2);
    bus.req = 1'b1; bus.io = 1'b1; bus.data_out = 32'hFFFFFFFF;
    wait_done("out2_done_timeout", 10);
    chk("out2_disp", display_data, 32'hFFFFFFFF);
    drop_req();
    cyc(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/io_controller.md
# io_controller

Sequencer between the processor's IN/OUT instruction path and the board I/O: switches, Confirm pushbutton and the eight 7-segment display value. It stalls the CPU during an IN until the operator presses and releases Confirm, then returns the zero-extended switch value. It latches OUT values into a display holding register, reporting completion of each transaction with a one-cycle Done pulse. Sits between the control unit and the display/switch decoding logic.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a Confirm level change (≥2).
- SWITCH_WIDTH, 18: width of Raw_Input; zero-extended to 32 on Data_In.

- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; all state cleared immediately.
- Req  in  1  CPU I/O transaction request, level; held until Done.
- IO  in  1  0 = input (IN), 1 = output (OUT); valid while Req high.
- Data_Out  in  32  value to display on OUT.
- Raw_Input  in  SWITCH_WIDTH  board switches, quasi-static.
- Confirm  in  1  raw pushbutton, active-high, asynchronous to Clock.
- Stall  out  1  freeze CPU PC/pipeline.
- Done  out  1  one-cycle completion pulse.
- Data_In  out  32  last captured switch value, zero-extended.
- Display_Data  out  32  last OUT value, feeds hex decoders.
- Display_Valid  out  1  high once any OUT has completed since reset (blank displays while low).
- Waiting  out  1  operator-prompt LED; high in WAIT_PRESS and WAIT_RELEASE.

## Operation
- Confirm path: 2-flop synchronizer → debouncer → Conf_Db; Conf_Prev registers Conf_Db for edge detection.
- States: IDLE, WAIT_PRESS, WAIT_RELEASE, OUT_WRITE, DONE.
- IDLE: Req && !IO → WAIT_PRESS; Req && IO → OUT_WRITE; else stay.
- WAIT_PRESS: on Conf_Db && !Conf_Prev (rising edge only), capture Raw_Input into a holding register → WAIT_RELEASE. Button already held on entry must be released and pressed again.
- WAIT_RELEASE: !Conf_Db → DONE, with Data_In ← holding register at the same edge.
- OUT_WRITE: Display_Data ← Data_Out; Display_Valid ← 1 → DONE.
- DONE: Done = 1 for exactly this cycle; unconditionally → IDLE. Req sampled at this edge is ignored. CPU must drop Req on seeing Done, or a new transaction starts from IDLE.
- Req falling in WAIT_PRESS, WAIT_RELEASE or OUT_WRITE aborts → IDLE: no Done; Data_In and Display_Data unchanged.
- Stall = Req && state ∉ {DONE}; combinational. It is high in the IDLE cycle where Req first rises.
- Data_In upper 32−SWITCH_WIDTH bits always 0.

## Timing
- Reset values: state IDLE, Stall 0 (given Req 0), Done 0, Data_In 0, Display_Data 0, Display_Valid 0, Waiting 0, synchronizer/debounce/holding registers 0, Conf_Db 0.
- OUT latency: Req sampled at edge 0 → OUT_WRITE; edge 1 updates Display_Data and enters DONE; Done high between edges 1 and 2; IDLE after edge 2. Three cycles total.
- IN latency after operator action: Confirm change → Conf_Db change after 2 sync cycles + DEBOUNCE_CYCLES; one further edge for the state transition.
- Debounce: counter increments each cycle the synchronized value ≠ Conf_Db and clears when equal. At DEBOUNCE_CYCLES−1 with the value still differing, Conf_Db toggles and the counter clears. A glitch shorter than DEBOUNCE_CYCLES cycles causes no change.
- Reset mid-transaction: immediate return to IDLE, no Done, outputs to reset values.

## Configuration
- IO_CONFIRM_DEBOUNCE_EN defined: debouncer per Timing; DEBOUNCE_CYCLES used.
- Not defined: Conf_Db = synchronizer output directly (2-cycle latency). DEBOUNCE_CYCLES is ignored and the counter is removed. For simulation or a pre-debounced button.

## Test plan
- Reset then OUT: Req=1, IO=1, Data_Out=0x1234ABCD → Display_Data=0x1234ABCD and Display_Valid=1 after edge 1; Done for one cycle at cycle 2; Stall high cycles 0–1.
- IN, DEBOUNCE_CYCLES=4: Req=1, IO=0, Raw_Input=0x2A5F3; Confirm high 10 cycles, then low → Waiting high; Data_In=0x0002A5F3 on entry to DONE; single Done; Stall drops in the Done cycle.
- Bounce: Confirm pulses 1–3 cycles wide, DEBOUNCE_CYCLES=4 → state stays WAIT_PRESS and Data_In unchanged (macro defined).
- Held button: Confirm high before Req → no capture until Confirm goes low then high; the captured value is Raw_Input at the second press.
- Abort: Req dropped in WAIT_RELEASE → IDLE, no Done, Data_In keeps its previous value (e.g. 0).
- Async reset asserted in WAIT_PRESS mid-cycle → outputs reset immediately, before the next Clock edge; Display_Valid=0.
